hazard_forward_unit: RTL

Tracks destination registers of in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages. Drives the 2-bit selectors of the two EX-stage operand MUX4to1 instances (operand A, operand B). Generates the load-use stall and the taken-branch flushes for the pipeline registers. Sits between decode and the EX-stage operand muxes and owns its own shadow copies of the pipeline control fields.

---
 rtl/hazard_pkg.sv | 48 ++++
 rtl/hazard_forward_unit_shadow_stage.sv | 28 ++
 rtl/hazard_forward_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding unit.
// Holds the forwarding-select encoding, the per-stage shadow record and
// the producer-match function used for both EX operands.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 2;

    // Operand mux selector encoding (2'b11 is never produced)
    typedef enum logic [SEL_W-1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Shadow copy of the control fields carried by one pipeline stage
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    // A stage produces a value only if it is real, writes, and targets a non-x0 register
    function automatic logic is_producer(input stage_t s);
        return s.valid && s.reg_write && (s.rd != '0);
    endfunction

    function automatic logic hits(input stage_t s, input logic [REG_ADDR_W-1:0] rs);
        return is_producer(s) && (s.rd == rs);
    endfunction

    // Newest producer wins: EX/MEM before MEM/WB, otherwise the register file
    function automatic fwd_sel_e fwd_select(input logic [REG_ADDR_W-1:0] rs,
                                            input stage_t exmem,
                                            input stage_t memwb);
        if (hits(exmem, rs)) begin
            return FWD_MEM;
        end
        if (hits(memwb, rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_shadow_stage.sv
// One registered shadow entry of the pipeline control fields.
// A bubble loads an empty (invalid) entry instead of the incoming one.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    stage_t q_reg;

    // Advance every cycle; reset and bubble both load an empty entry
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= STAGE_EMPTY;
        end else if (bubble) begin
            q_reg <= STAGE_EMPTY;
        end else begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Shadows ID/EX, EX/MEM and MEM/WB control fields, drives the EX operand
// mux selects, the load-use stall and the taken-branch flushes.
// Optional feature macro: HAZARD_FORWARDING_EN (defined = forwarding with
// load-use stall only; undefined = no forwarding, stall on any EX/MEM-or-newer
// producer match).
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int RegAddrWidth = REG_ADDR_W,
    parameter int SelWidth     = SEL_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [RegAddrWidth-1:0] id_rs1,
    input  logic [RegAddrWidth-1:0] id_rs2,
    input  logic [RegAddrWidth-1:0] id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    ex_branch_taken,
    output logic [SelWidth-1:0]     fwd_sel_a,
    output logic [SelWidth-1:0]     fwd_sel_b,
    output logic                    stall,
    output logic                    flush_ifid,
    output logic                    flush_idex
);

    localparam int NUM_STAGES = 3;   // 0: ID/EX, 1: EX/MEM, 2: MEM/WB

    stage_t id_stage;
    stage_t chain_d [NUM_STAGES];
    stage_t chain_q [NUM_STAGES];
    logic   idex_bubble;
    logic   load_use;

    logic [RegAddrWidth-1:0] idex_rs1_reg;
    logic [RegAddrWidth-1:0] idex_rs2_reg;

    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    assign id_stage = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    // A stall or a taken branch both leave an empty slot behind in ID/EX
    assign idex_bubble = stall | ex_branch_taken;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign chain_d[gi] = id_stage;
            end else begin : g_tail
                assign chain_d[gi] = chain_q[gi-1];
            end

            hazard_shadow_stage u_stage (
                .clk    (clk),
                .reset  (reset),
                .bubble ((gi == 0) ? idex_bubble : 1'b0),
                .d      (chain_d[gi]),
                .q      (chain_q[gi])
            );
        end
    endgenerate

    // Source registers of the instruction entering EX, cleared with a bubble
    always_ff @(posedge clk) begin
        if (reset || idex_bubble) begin
            idex_rs1_reg <= '0;
            idex_rs2_reg <= '0;
        end else begin
            idex_rs1_reg <= id_rs1;
            idex_rs2_reg <= id_rs2;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Forward from the newest producer; only a load one stage ahead forces a stall
    always_comb begin
        fwd_a    = fwd_select(idex_rs1_reg, chain_q[1], chain_q[2]);
        fwd_b    = fwd_select(idex_rs2_reg, chain_q[1], chain_q[2]);
        load_use = id_valid && chain_q[0].mem_read &&
                   (hits(chain_q[0], id_rs1) || hits(chain_q[0], id_rs2));
    end
`else
    // No bypass paths: wait until the producer has reached MEM/WB (write-first RF)
    always_comb begin
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        load_use = id_valid &&
                   (hits(chain_q[0], id_rs1) || hits(chain_q[0], id_rs2) ||
                    hits(chain_q[1], id_rs1) || hits(chain_q[1], id_rs2));
    end
`endif

    assign fwd_sel_a  = fwd_a;
    assign fwd_sel_b  = fwd_b;
    // A taken branch discards the decode instruction, so it never stalls
    assign stall      = load_use & ~ex_branch_taken;
    assign flush_ifid = ex_branch_taken;
    assign flush_idex = ex_branch_taken;

    // Fields that the selected build does not consume
    logic unused_sink;
    assign unused_sink = ^{chain_q[2], idex_rs1_reg, idex_rs2_reg};

endmodule
